dffnrsnq_force_seq: RTL and testbench

Sequencer driving the per-bit asynchronous set/reset pins of a bank of negative-edge set/reset flops (dffnrsnq cells).
- Upstream stage of that bank: on a four-phase request it forces the bank to an arbitrary pattern through the SETN/RN pins, holds the force, then releases it on the rising CLKN edge, half a cycle before the bank's active falling edge.
- Also generates the bank's power-on reset with synchronous deassertion.
- Guarantees that SETN and RN are never both low on the same bit.

---
 rtl/dffnrsnq_force_seq_if.sv | 37 +++
 rtl/dffnrsnq_force_seq.sv | 170 +++++++++++++++++
 tb/tb_dffnrsnq_force_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dffnrsnq_force_seq_if.sv
// dffnrsnq_force_seq_if
//   Request-side bundle of the force sequencer.
//   REQ/PATTERN come from the requester; ACK/BUSY/ERR go back to it.
//
//   Handshake: four-phase. The requester raises REQ with PATTERN valid and
//   keeps PATTERN stable until ACK rises. The sequencer raises ACK once the
//   force has been applied and released. The requester then drops REQ, and
//   ACK falls on the next rising CLKN edge. A new REQ is only taken while
//   ACK is low and the sequencer is idle.
//
//   master : requester side (drives REQ, PATTERN)
//   slave  : sequencer side (drives ACK, BUSY, ERR)
interface dffnrsnq_force_seq_if #(
  parameter int WIDTH = 8
);
  logic             REQ;
  logic [WIDTH-1:0] PATTERN;
  logic             ACK;
  logic             BUSY;
  logic             ERR;

  modport master (
    output REQ,
    output PATTERN,
    input  ACK,
    input  BUSY,
    input  ERR
  );

  modport slave (
    input  REQ,
    input  PATTERN,
    output ACK,
    output BUSY,
    output ERR
  );
endinterface

// File: rtl/dffnrsnq_force_seq.sv
// dffnrsnq_force_seq
//   Drives the per-bit SETN/RN pins of a bank of negative-edge set/reset
//   flops. A four-phase request forces the bank to PATTERN for HOLD cycles,
//   then releases the force on a rising CLKN edge, half a period ahead of
//   the bank's active falling edge. Also produces the bank power-on reset
//   with a synchronised deassertion. SETN_O[i] and RN_O[i] are never both 0.
//
// Parameters
//   WIDTH       : flops in the bank (1..64)
//   HOLD        : rising-CLKN cycles the force is held (1..15)
//   SYNC_STAGES : reset deassertion synchroniser depth (2..4)
//
// Ports
//   CLKN      in   bank clock; this block runs on its rising edge
//   RN        in   asynchronous active-low reset
//   req_if    slave REQ/PATTERN in, ACK/BUSY/ERR out
//   Q_FB      in   bank Q feedback (readback build only)
//   SETN_O    out  per-bit active-low set to the bank
//   RN_O      out  per-bit active-low reset to the bank
//   state_dbg out  current FSM state encoding
//
// Build option
//   DFFNRSNQ_FORCE_SEQ_READBACK_EN : when defined, Q_FB is compared with the
//   captured pattern on the edge that leaves FORCE (force still applied);
//   a mismatch sets ERR until the next accepted request or reset. When not
//   defined, ERR is tied 0 and Q_FB is ignored. Timing is identical.
module dffnrsnq_force_seq #(
  parameter int WIDTH       = 8,
  parameter int HOLD        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLKN,
  input  logic                   RN,
  dffnrsnq_force_seq_if.slave    req_if,
  input  logic [WIDTH-1:0]       Q_FB,
  output logic [WIDTH-1:0]       SETN_O,
  output logic [WIDTH-1:0]       RN_O,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    RST_SYNC = 2'd0,
    IDLE     = 2'd1,
    FORCE    = 2'd2,
    ACKW     = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       setn_q, setn_d;
  logic [WIDTH-1:0]       rn_q, rn_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
  logic [WIDTH-1:0]       p_q, p_d;
  logic                   err_q, err_d;
`endif

  always_ff @(posedge CLKN or negedge RN) begin
    if (!RN) begin
      state_q <= RST_SYNC;
      sync_q  <= '0;
      cnt_q   <= '0;
      setn_q  <= '1;
      rn_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
      p_q     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      setn_q  <= setn_d;
      rn_q    <= rn_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
      p_q     <= p_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    // Shift register of 1s; it keeps saturating outside RST_SYNC, which is
    // harmless because only RST_SYNC looks at it.
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d   = cnt_q;
    setn_d  = setn_q;
    rn_d    = rn_q;
    ack_d   = ack_q;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
    p_d     = p_q;
    err_d   = err_q;
`endif

    case (state_q)
      RST_SYNC: begin
        // Leave on the edge that fills the last stage, so RN_O releases
        // exactly SYNC_STAGES rising edges after RN goes high.
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = IDLE;
          rn_d    = '1;
          setn_d  = '1;
        end
      end
      IDLE: begin
        if (req_if.REQ && !ack_q) begin
          state_d = FORCE;
          // Complementary drive keeps SETN|RN = 1 on every bit.
          setn_d  = ~req_if.PATTERN;
          rn_d    = req_if.PATTERN;
          cnt_d   = HOLD_M1;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
          p_d     = req_if.PATTERN;
          err_d   = 1'b0;
`endif
        end
      end
      FORCE: begin
        // REQ is not looked at here: a dropped request still completes.
        if (cnt_q == 4'd0) begin
          state_d = ACKW;
          setn_d  = '1;
          rn_d    = '1;
          ack_d   = 1'b1;
`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
          // Q_FB is sampled while the force is still on the bank pins.
          err_d   = err_q | (Q_FB != p_q);
`endif
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ACKW: begin
        if (!req_if.REQ) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = RST_SYNC;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign SETN_O      = setn_q;
  assign RN_O        = rn_q;
  assign req_if.ACK  = ack_q;
  assign req_if.BUSY = busy_q;
  assign state_dbg   = state_q;

`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
  assign req_if.ERR  = err_q;
`else
  assign req_if.ERR  = 1'b0;
  logic unused_q_fb;
  assign unused_q_fb = ^Q_FB;
`endif

endmodule

// File: tb/tb_dffnrsnq_force_seq.sv
module tb_dffnrsnq_force_seq;

`ifdef DFFNRSNQ_FORCE_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       CLKN;
  logic       RN;
  logic [7:0] Q_FB;
  logic [7:0] SETN_O;
  logic [7:0] RN_O;
  logic [1:0] state_dbg;

  dffnrsnq_force_seq_if #(.WIDTH(8)) bus ();

  dffnrsnq_force_seq #(.WIDTH(8), .HOLD(2), .SYNC_STAGES(2)) dut (
    .CLKN      (CLKN),
    .RN        (RN),
    .req_if    (bus),
    .Q_FB      (Q_FB),
    .SETN_O    (SETN_O),
    .RN_O      (RN_O),
    .state_dbg (state_dbg)
  );

  initial CLKN = 1'b0;
  always #5 CLKN = ~CLKN;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLKN);
    #1;
  endtask

  // SETN_O | RN_O must be all ones on every cycle.
  always @(negedge CLKN) begin
    total++;
    if ((SETN_O | RN_O) !== 8'hFF) begin
      bad++;
      $display("FAIL invariant: setn=%0h rn=%0h exp_or=ff at %0t", SETN_O, RN_O, $time);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       req;
    logic [7:0] pat;
    logic [7:0] qfb;
    logic [7:0] setn;
    logic [7:0] rn;
    logic       ack;
    logic       busy;
    logic       err_rb;  // expected ERR when readback is compiled in
  } vec_t;

  vec_t vecs[17];

  initial begin
    // A: PATTERN=A5, REQ held through ACK
    vecs[0]  = '{1'b1, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    // B: one-cycle REQ, feedback off by one bit at release
    vecs[5]  = '{1'b1, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h3C, 8'h3D, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h3C, 8'h3D, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};
    // C: back-to-back at the minimum period, all-0 then all-1
    vecs[9]  = '{1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    RN          = 1'b1;
    bus.REQ     = 1'b0;
    bus.PATTERN = 8'h00;
    Q_FB        = 8'h00;
    #2 RN = 1'b0;

    // Reset values and synchronised exit
    repeat (3) tick();
    check("rst_rn_o",  32'(RN_O),      32'h00);
    check("rst_setn",  32'(SETN_O),    32'hFF);
    check("rst_busy",  32'(bus.BUSY),  32'h1);
    check("rst_ack",   32'(bus.ACK),   32'h0);
    check("rst_err",   32'(bus.ERR),   32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    RN = 1'b1;
    tick();
    check("sync1_rn_o", 32'(RN_O),     32'h00);
    check("sync1_busy", 32'(bus.BUSY), 32'h1);
    tick();
    check("sync2_rn_o",  32'(RN_O),      32'hFF);
    check("sync2_setn",  32'(SETN_O),    32'hFF);
    check("sync2_busy",  32'(bus.BUSY),  32'h0);
    check("sync2_state", 32'(state_dbg), 32'h1);

    // Table-driven force sequences
    for (int i = 0; i < 17; i++) begin
      bus.REQ     = vecs[i].req;
      bus.PATTERN = vecs[i].pat;
      Q_FB        = vecs[i].qfb;
      tick();
      check($sformatf("v%0d_setn", i), 32'(SETN_O),   32'(vecs[i].setn));
      check($sformatf("v%0d_rn",   i), 32'(RN_O),     32'(vecs[i].rn));
      check($sformatf("v%0d_ack",  i), 32'(bus.ACK),  32'(vecs[i].ack));
      check($sformatf("v%0d_busy", i), 32'(bus.BUSY), 32'(vecs[i].busy));
      check($sformatf("v%0d_err",  i), 32'(bus.ERR),  32'(RB ? vecs[i].err_rb : 1'b0));
    end

    // Reset during the second hold cycle
    bus.REQ     = 1'b1;
    bus.PATTERN = 8'h5A;
    Q_FB        = 8'h5A;
    tick();
    check("mf_setn1", 32'(SETN_O), 32'hA5);
    check("mf_rn1",   32'(RN_O),   32'h5A);
    bus.REQ = 1'b0;
    tick();
    check("mf_rn2", 32'(RN_O), 32'h5A);
    #2 RN = 1'b0;
    #1;
    check("mf_async_rn_o", 32'(RN_O),     32'h00);
    check("mf_async_setn", 32'(SETN_O),   32'hFF);
    check("mf_async_ack",  32'(bus.ACK),  32'h0);
    check("mf_async_busy", 32'(bus.BUSY), 32'h1);
    check("mf_async_err",  32'(bus.ERR),  32'h0);
    tick();
    RN = 1'b1;
    tick();
    tick();
    check("mf_resync_rn_o", 32'(RN_O),     32'hFF);
    check("mf_resync_busy", 32'(bus.BUSY), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mf_noack%0d", i),  32'(bus.ACK),  32'h0);
      check($sformatf("mf_nobusy%0d", i), 32'(bus.BUSY), 32'h0);
    end

    // Fresh request after the aborted one
    bus.REQ     = 1'b1;
    bus.PATTERN = 8'h81;
    Q_FB        = 8'h81;
    tick();
    check("nr_setn", 32'(SETN_O), 32'h7E);
    check("nr_rn",   32'(RN_O),   32'h81);
    tick();
    tick();
    check("nr_ack",     32'(bus.ACK), 32'h1);
    check("nr_release", 32'(SETN_O & RN_O), 32'hFF);
    check("nr_err",     32'(bus.ERR), 32'h0);
    bus.REQ = 1'b0;
    tick();
    check("nr_ack_drop", 32'(bus.ACK),  32'h0);
    check("nr_idle",     32'(bus.BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
